// File: rtl/transport_scheduler.sv
// -----------------------------------------------------------------------------
// transport_scheduler
//
// Purpose:
//    Arbitrates between a control-data requester and an audio requester for a
//    single transport command port, and independently issues send-packet
//    pulses once the transport has a full packet ready and the link is free.
//    Handshake stalls on either side set a sticky timeout flag.
//
// Parameters:
//    PACKET_SIZE   bytes per packet; send threshold on ts_ready_count
//    AU_WAIT_MAX   cycles a pending audio request may lose to control
//    BUSY_TIMEOUT  cycles to wait for ts_busy / ts_sending to rise
//
// Ports:
//    clk, reset                 clock; asynchronous active-high reset
//    cd_req/cd_data/cd_ack      control requester handshake (ack = 1-cycle pulse)
//    au_req/au_data/au_ack      audio requester handshake (ack = 1-cycle pulse)
//    ts_cmd/ts_data             transport command (00 idle, 01 ctrl, 10 audio)
//    ts_busy                    transport busy flag
//    ts_ready_count             bytes waiting in the transport ready FIFO
//    ts_sending                 transport packet-out active
//    link_ready                 downstream can take a packet
//    ts_send                    1-cycle send-packet pulse
//    err_timeout                sticky handshake-timeout flag
//    pkt_count                  packets sent (statistics build only)
//
// Build option:
//    TS_SCHED_STATS_EN  when defined, pkt_count counts completed packets;
//                       otherwise pkt_count is tied to zero.
//
// Timing: the grant decision is registered, so the ack pulse, ts_cmd and the
// new ts_data word are all visible together in the single A_ISSUE cycle.
// Likewise ts_send is visible exactly while the send FSM sits in S_PULSE.
// -----------------------------------------------------------------------------
module transport_scheduler #(
   parameter int PACKET_SIZE  = 16,
   parameter int AU_WAIT_MAX  = 8,
   parameter int BUSY_TIMEOUT = 7
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cd_req,
   input  logic [15:0] cd_data,
   output logic        cd_ack,
   input  logic        au_req,
   input  logic [15:0] au_data,
   output logic        au_ack,
   output logic [1:0]  ts_cmd,
   output logic [15:0] ts_data,
   input  logic        ts_busy,
   input  logic [10:0] ts_ready_count,
   input  logic        ts_sending,
   input  logic        link_ready,
   output logic        ts_send,
   output logic        err_timeout,
   output logic [15:0] pkt_count
);

   localparam int TW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
   localparam int AW = $clog2(AU_WAIT_MAX + 1);

   localparam logic [TW-1:0] TO_LAST  = TW'(BUSY_TIMEOUT - 1);
   localparam logic [TW-1:0] TO_ONE   = TW'(1);
   localparam logic [TW-1:0] TO_ZERO  = TW'(0);
   localparam logic [AW-1:0] AU_MAX   = AW'(AU_WAIT_MAX);
   localparam logic [AW-1:0] AU_ONE   = AW'(1);
   localparam logic [AW-1:0] AU_ZERO  = AW'(0);
   localparam logic [10:0]   PKT_THR  = 11'(PACKET_SIZE);

   localparam logic [1:0] CMD_IDLE = 2'b00;
   localparam logic [1:0] CMD_CTRL = 2'b01;
   localparam logic [1:0] CMD_AUD  = 2'b10;

   typedef enum logic [1:0] {
      A_IDLE  = 2'd0,
      A_ISSUE = 2'd1,
      A_WAITB = 2'd2,
      A_WAITD = 2'd3
   } arb_state_e;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_PULSE  = 2'd1,
      S_ACTIVE = 2'd2,
      S_DRAIN  = 2'd3
   } snd_state_e;

   arb_state_e    a_q, a_d;
   snd_state_e    s_q, s_d;
   logic [TW-1:0] a_cnt_q, a_cnt_d;
   logic [TW-1:0] s_cnt_q, s_cnt_d;
   logic [AW-1:0] au_wait_q, au_wait_d;
   logic          cd_ack_q, cd_ack_d;
   logic          au_ack_q, au_ack_d;
   logic [1:0]    ts_cmd_q, ts_cmd_d;
   logic [15:0]   ts_data_q, ts_data_d;
   logic          ts_send_q, ts_send_d;
   logic          err_q, err_d;
   logic          grant_au_s;
   logic          a_tmo_s;
   logic          s_tmo_s;

   // Arbiter next-state: grant decision, command issue and busy handshake
   always_comb begin
      a_d        = a_q;
      a_cnt_d    = a_cnt_q;
      cd_ack_d   = 1'b0;
      au_ack_d   = 1'b0;
      ts_cmd_d   = CMD_IDLE;
      ts_data_d  = ts_data_q;
      grant_au_s = 1'b0;
      a_tmo_s    = 1'b0;
      case (a_q)
         A_IDLE: begin
            // Control has priority unless audio has already waited its limit
            if (cd_req && !(au_req && (au_wait_q == AU_MAX))) begin
               cd_ack_d  = 1'b1;
               ts_cmd_d  = CMD_CTRL;
               ts_data_d = cd_data;
               a_d       = A_ISSUE;
            end else if (au_req) begin
               au_ack_d   = 1'b1;
               ts_cmd_d   = CMD_AUD;
               ts_data_d  = au_data;
               grant_au_s = 1'b1;
               a_d        = A_ISSUE;
            end else begin
               a_d = A_IDLE;
            end
         end
         A_ISSUE: begin
            a_d     = A_WAITB;
            a_cnt_d = TO_ZERO;
         end
         A_WAITB: begin
            if (ts_busy) begin
               a_d = A_WAITD;
            end else if (a_cnt_q == TO_LAST) begin
               a_d     = A_IDLE;
               a_tmo_s = 1'b1;
            end else begin
               a_cnt_d = a_cnt_q + TO_ONE;
            end
         end
         A_WAITD: begin
            if (!ts_busy) begin
               a_d = A_IDLE;
            end else begin
               a_d = A_WAITD;
            end
         end
         default: begin
            a_d = A_IDLE;
         end
      endcase
   end

   // Audio starvation counter: counts cycles audio is pending but not granted
   always_comb begin
      au_wait_d = au_wait_q;
      if (!au_req) begin
         au_wait_d = AU_ZERO;
      end else if (grant_au_s) begin
         au_wait_d = AU_ZERO;
      end else if (au_wait_q == AU_MAX) begin
         au_wait_d = AU_MAX;
      end else begin
         au_wait_d = au_wait_q + AU_ONE;
      end
   end

   // Send next-state: packet threshold check, send pulse and sending handshake
   always_comb begin
      s_d       = s_q;
      s_cnt_d   = s_cnt_q;
      ts_send_d = 1'b0;
      s_tmo_s   = 1'b0;
      case (s_q)
         S_IDLE: begin
            if (link_ready && (ts_ready_count >= PKT_THR) && !ts_sending) begin
               s_d       = S_PULSE;
               ts_send_d = 1'b1;
            end else begin
               s_d = S_IDLE;
            end
         end
         S_PULSE: begin
            s_d     = S_ACTIVE;
            s_cnt_d = TO_ZERO;
         end
         S_ACTIVE: begin
            if (ts_sending) begin
               s_d = S_DRAIN;
            end else if (s_cnt_q == TO_LAST) begin
               s_d     = S_IDLE;
               s_tmo_s = 1'b1;
            end else begin
               s_cnt_d = s_cnt_q + TO_ONE;
            end
         end
         S_DRAIN: begin
            if (!ts_sending) begin
               s_d = S_IDLE;
            end else begin
               s_d = S_DRAIN;
            end
         end
         default: begin
            s_d = S_IDLE;
         end
      endcase
   end

   // Timeout flag is sticky until reset
   always_comb begin
      err_d = err_q | a_tmo_s | s_tmo_s;
   end

   // State, counter and output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a_q       <= A_IDLE;
         s_q       <= S_IDLE;
         a_cnt_q   <= TO_ZERO;
         s_cnt_q   <= TO_ZERO;
         au_wait_q <= AU_ZERO;
         cd_ack_q  <= 1'b0;
         au_ack_q  <= 1'b0;
         ts_cmd_q  <= CMD_IDLE;
         ts_data_q <= 16'h0000;
         ts_send_q <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         a_q       <= a_d;
         s_q       <= s_d;
         a_cnt_q   <= a_cnt_d;
         s_cnt_q   <= s_cnt_d;
         au_wait_q <= au_wait_d;
         cd_ack_q  <= cd_ack_d;
         au_ack_q  <= au_ack_d;
         ts_cmd_q  <= ts_cmd_d;
         ts_data_q <= ts_data_d;
         ts_send_q <= ts_send_d;
         err_q     <= err_d;
      end
   end

`ifdef TS_SCHED_STATS_EN
   logic        pkt_inc_s;
   logic [15:0] pkt_q;

   assign pkt_inc_s = (s_q == S_DRAIN) && !ts_sending;

   // Completed-packet counter, wraps naturally at 16 bits
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pkt_q <= 16'h0000;
      end else if (pkt_inc_s) begin
         pkt_q <= pkt_q + 16'h0001;
      end else begin
         pkt_q <= pkt_q;
      end
   end

   assign pkt_count = pkt_q;
`else
   assign pkt_count = 16'h0000;
`endif

   assign cd_ack      = cd_ack_q;
   assign au_ack      = au_ack_q;
   assign ts_cmd      = ts_cmd_q;
   assign ts_data     = ts_data_q;
   assign ts_send     = ts_send_q;
   assign err_timeout = err_q;

endmodule

// File: tb/tb_transport_scheduler.sv
// -----------------------------------------------------------------------------
// tb_transport_scheduler
//
// Directed bench for transport_scheduler with default parameters
// (PACKET_SIZE 16, AU_WAIT_MAX 8, BUSY_TIMEOUT 7). Inputs are driven and
// outputs sampled 1 time unit after each rising clock edge.
// -----------------------------------------------------------------------------
module tb_transport_scheduler;

   logic        clk = 1'b0;
   logic        reset;
   logic        cd_req;
   logic [15:0] cd_data;
   logic        cd_ack;
   logic        au_req;
   logic [15:0] au_data;
   logic        au_ack;
   logic [1:0]  ts_cmd;
   logic [15:0] ts_data;
   logic        ts_busy;
   logic [10:0] ts_ready_count;
   logic        ts_sending;
   logic        link_ready;
   logic        ts_send;
   logic        err_timeout;
   logic [15:0] pkt_count;

   int checks = 0;
   int errors = 0;

`ifdef TS_SCHED_STATS_EN
   localparam logic [15:0] PKT_AFTER_ONE = 16'h0001;
`else
   localparam logic [15:0] PKT_AFTER_ONE = 16'h0000;
`endif

   always #5 clk = ~clk;

   transport_scheduler dut (
      .clk            (clk),
      .reset          (reset),
      .cd_req         (cd_req),
      .cd_data        (cd_data),
      .cd_ack         (cd_ack),
      .au_req         (au_req),
      .au_data        (au_data),
      .au_ack         (au_ack),
      .ts_cmd         (ts_cmd),
      .ts_data        (ts_data),
      .ts_busy        (ts_busy),
      .ts_ready_count (ts_ready_count),
      .ts_sending     (ts_sending),
      .link_ready     (link_ready),
      .ts_send        (ts_send),
      .err_timeout    (err_timeout),
      .pkt_count      (pkt_count)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Waits (bounded) for either ack, then checks the winner and drives a
   // short busy handshake: busy high one cycle, then low.
   task automatic serve(input string tag, input logic exp_au);
      int n;
      n = 0;
      do begin
         tick();
         n++;
      end while (!(cd_ack || au_ack) && (n < 16));
      chk({tag, "_cd_ack"}, {15'd0, cd_ack}, {15'd0, !exp_au});
      chk({tag, "_au_ack"}, {15'd0, au_ack}, {15'd0, exp_au});
      chk({tag, "_cmd"}, {14'd0, ts_cmd}, exp_au ? 16'h0002 : 16'h0001);
      chk({tag, "_data"}, ts_data, exp_au ? 16'h2222 : 16'h1111);
      tick();
      ts_busy = 1'b1;
      tick();
      ts_busy = 1'b0;
   endtask

   initial begin
      reset          = 1'b1;
      cd_req         = 1'b0;
      cd_data        = 16'h0000;
      au_req         = 1'b0;
      au_data        = 16'h0000;
      ts_busy        = 1'b0;
      ts_ready_count = 11'd0;
      ts_sending     = 1'b0;
      link_ready     = 1'b0;

      // ---- reset state ----
      tick(); tick(); tick();
      chk("rst_cd_ack", {15'd0, cd_ack}, 16'h0000);
      chk("rst_au_ack", {15'd0, au_ack}, 16'h0000);
      chk("rst_cmd", {14'd0, ts_cmd}, 16'h0000);
      chk("rst_data", ts_data, 16'h0000);
      chk("rst_send", {15'd0, ts_send}, 16'h0000);
      chk("rst_err", {15'd0, err_timeout}, 16'h0000);
      chk("rst_pkt", pkt_count, 16'h0000);
      reset = 1'b0;
      tick();

      // ---- single control transfer, busy rises 2 cycles after ts_cmd ----
      cd_data = 16'hA55A;
      cd_req  = 1'b1;
      tick();
      chk("c1_cd_ack", {15'd0, cd_ack}, 16'h0001);
      chk("c1_au_ack", {15'd0, au_ack}, 16'h0000);
      chk("c1_cmd", {14'd0, ts_cmd}, 16'h0001);
      chk("c1_data", ts_data, 16'hA55A);
      cd_req = 1'b0;
      tick();
      chk("c2_cd_ack", {15'd0, cd_ack}, 16'h0000);
      chk("c2_cmd", {14'd0, ts_cmd}, 16'h0000);
      chk("c2_data_hold", ts_data, 16'hA55A);
      tick();
      ts_busy = 1'b1;
      tick();
      // arbiter now waits for busy to fall; a new audio request must wait
      au_data = 16'h5A5A;
      au_req  = 1'b1;
      tick();
      chk("c5_no_grant", {15'd0, au_ack}, 16'h0000);
      ts_busy = 1'b0;
      tick();
      chk("c6_no_grant", {15'd0, au_ack}, 16'h0000);
      chk("c6_cmd", {14'd0, ts_cmd}, 16'h0000);
      tick();
      chk("c7_au_ack", {15'd0, au_ack}, 16'h0001);
      chk("c7_cmd", {14'd0, ts_cmd}, 16'h0002);
      chk("c7_data", ts_data, 16'h5A5A);
      au_req = 1'b0;
      tick();
      ts_busy = 1'b1;
      tick();
      ts_busy = 1'b0;
      tick();
      chk("c10_err", {15'd0, err_timeout}, 16'h0000);

      // ---- send threshold: 15 never sends, 16 sends once ----
      link_ready     = 1'b1;
      ts_ready_count = 11'd15;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("s15_no_send", {15'd0, ts_send}, 16'h0000);
      end
      ts_ready_count = 11'd20;
      ts_sending     = 1'b1;
      tick();
      tick();
      chk("s_busy_link_no_send", {15'd0, ts_send}, 16'h0000);
      ts_sending     = 1'b0;
      ts_ready_count = 11'd16;
      tick();
      chk("s16_send", {15'd0, ts_send}, 16'h0001);
      ts_ready_count = 11'd0;
      tick();
      chk("s16_send_end", {15'd0, ts_send}, 16'h0000);
      ts_sending = 1'b1;
      tick();
      chk("s_pkt_before", pkt_count, 16'h0000);
      ts_sending = 1'b0;
      tick();
      chk("s_pkt_after", pkt_count, PKT_AFTER_ONE);
      chk("s_send_idle", {15'd0, ts_send}, 16'h0000);
      chk("s_err", {15'd0, err_timeout}, 16'h0000);
      link_ready = 1'b0;
      tick();

      // ---- both requesters held: control, control, audio, repeating ----
      cd_data = 16'h1111;
      au_data = 16'h2222;
      cd_req  = 1'b1;
      au_req  = 1'b1;
      serve("arb1", 1'b0);
      serve("arb2", 1'b0);
      serve("arb3", 1'b1);
      serve("arb4", 1'b0);
      serve("arb5", 1'b0);
      serve("arb6", 1'b1);
      cd_req = 1'b0;
      au_req = 1'b0;
      tick();
      tick();
      tick();

      // ---- busy never rises: timeout; withdrawn audio request is never acked ----
      cd_data = 16'hBEEF;
      cd_req  = 1'b1;
      tick();
      chk("t1_cd_ack", {15'd0, cd_ack}, 16'h0001);
      cd_req = 1'b0;
      for (int i = 2; i <= 8; i++) begin
         tick();
         if (i == 2) au_req = 1'b1;
         if (i == 4) au_req = 1'b0;
      end
      chk("t8_err_low", {15'd0, err_timeout}, 16'h0000);
      tick();
      chk("t9_err_high", {15'd0, err_timeout}, 16'h0001);
      chk("t9_au_ack", {15'd0, au_ack}, 16'h0000);
      tick();
      chk("t10_au_ack", {15'd0, au_ack}, 16'h0000);
      chk("t10_cmd", {14'd0, ts_cmd}, 16'h0000);
      for (int i = 0; i < 5; i++) begin
         tick();
      end
      chk("t_err_sticky", {15'd0, err_timeout}, 16'h0001);

      // ---- reset asserted in A_WAITD with a send pulse in flight ----
      cd_data = 16'hC3C3;
      cd_req  = 1'b1;
      tick();
      chk("r1_cd_ack", {15'd0, cd_ack}, 16'h0001);
      cd_req = 1'b0;
      tick();
      ts_busy        = 1'b1;
      link_ready     = 1'b1;
      ts_ready_count = 11'd16;
      tick();
      chk("r3_send", {15'd0, ts_send}, 16'h0001);
      #2;
      reset = 1'b1;
      #1;
      chk("r_async_cd_ack", {15'd0, cd_ack}, 16'h0000);
      chk("r_async_cmd", {14'd0, ts_cmd}, 16'h0000);
      chk("r_async_data", ts_data, 16'h0000);
      chk("r_async_send", {15'd0, ts_send}, 16'h0000);
      chk("r_async_err", {15'd0, err_timeout}, 16'h0000);
      chk("r_async_pkt", pkt_count, 16'h0000);
      ts_busy        = 1'b0;
      ts_ready_count = 11'd0;
      tick();
      tick();
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("r_post_cd_ack", {15'd0, cd_ack}, 16'h0000);
         chk("r_post_cmd", {14'd0, ts_cmd}, 16'h0000);
         chk("r_post_send", {15'd0, ts_send}, 16'h0000);
      end
      chk("r_post_err", {15'd0, err_timeout}, 16'h0000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
